gain_scheduler: RTL and testbench

GAIN_SCHEDULER -- requirements
Module: gain_scheduler

---
 rtl/gain_sched_pkg.sv | 24 ++
 rtl/gain_tag_fifo.sv | 64 ++++++
 rtl/gain_scheduler.sv | 132 +++++++++++++
 tb/tb_gain_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gain_sched_pkg.sv
// ============================================================================
// gain_sched_pkg : shared types and constants for the gain scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

package gain_sched_pkg;

    localparam int DATA_SIZE_DEFAULT = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_t;

endpackage

`default_nettype wire

// File: rtl/gain_tag_fifo.sv
// ============================================================================
// gain_tag_fifo : 1-bit synchronous FIFO, simultaneous push/pop, count output
// Revision 1.0
// ============================================================================
`default_nettype none

module gain_tag_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          din,
    input  logic          pop,
    output logic          dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // A push into a full FIFO is accepted only when a pop frees the slot.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != c_depth) || w_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/gain_scheduler.sv
// ============================================================================
// gain_scheduler : round-robin L/R sharing of one gain unit, drained volume swap
// Optional macro GAIN_SCHED_MUTE_EN adds a mute input. Revision 1.0
// ============================================================================
`default_nettype none

module gain_scheduler
    import gain_sched_pkg::*;
#(
    parameter int                          DATA_SIZE       = DATA_SIZE_DEFAULT,
    parameter int                          MAX_OUTSTANDING = 4,
    parameter logic signed [DATA_SIZE-1:0] VOLUME_RESET    = 32'sd1024
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic signed [DATA_SIZE-1:0] left_in,
    input  logic signed [DATA_SIZE-1:0] right_in,
    input  logic                        left_empty,
    input  logic                        right_empty,
    output logic                        left_rd_en,
    output logic                        right_rd_en,
    output logic signed [DATA_SIZE-1:0] mul_din,
    output logic                        mul_wr_en,
    input  logic                        mul_full,
    input  logic signed [DATA_SIZE-1:0] mul_dout,
    input  logic                        mul_empty,
    output logic                        mul_rd_en,
    output logic signed [DATA_SIZE-1:0] volume,
    input  logic signed [DATA_SIZE-1:0] vol_in,
    input  logic                        vol_req,
    output logic signed [DATA_SIZE-1:0] left_out,
    output logic signed [DATA_SIZE-1:0] right_out,
    output logic                        left_wr_en,
    output logic                        right_wr_en,
    input  logic                        left_full,
    input  logic                        right_full,
`ifdef GAIN_SCHED_MUTE_EN
    input  logic                        mute,
`endif
    output logic                        busy
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    state_t                        r_state;
    chan_t                         r_last_grant;
    logic signed [DATA_SIZE-1:0]   r_volume;
    logic signed [DATA_SIZE-1:0]   r_pending_vol;

    logic [CW-1:0]                 w_count;
    logic                          w_tag_full;
    logic                          w_tag_empty;
    logic                          w_tag_head;
    chan_t                         w_grant;
    logic                          w_issue;
    logic                          w_retire;
    logic                          w_head_full;
    logic signed [DATA_SIZE-1:0]   w_sample;

    // Handshakes are gated by reset_n so every strobe drops the instant reset asserts.
    always_comb begin
        w_grant = LEFT;
        if (!left_empty && !right_empty) w_grant = (r_last_grant == LEFT) ? RIGHT : LEFT;
        else if (left_empty)             w_grant = RIGHT;
    end

    assign w_issue     = reset_n && (r_state == RUN) && !mul_full && !w_tag_full &&
                         (!left_empty || !right_empty);
    assign w_head_full = w_tag_head ? right_full : left_full;
    assign w_retire    = reset_n && !mul_empty && !w_tag_empty && !w_head_full;

`ifdef GAIN_SCHED_MUTE_EN
    assign w_sample = mute ? '0 : mul_dout;
`else
    assign w_sample = mul_dout;
`endif

    assign left_rd_en  = w_issue && (w_grant == LEFT);
    assign right_rd_en = w_issue && (w_grant == RIGHT);
    assign mul_wr_en   = w_issue;
    assign mul_din     = !w_issue ? '0 : ((w_grant == LEFT) ? left_in : right_in);
    assign mul_rd_en   = w_retire;
    assign left_wr_en  = w_retire && !w_tag_head;
    assign right_wr_en = w_retire && w_tag_head;
    assign left_out    = left_wr_en  ? w_sample : '0;
    assign right_out   = right_wr_en ? w_sample : '0;
    assign volume      = r_volume;
    assign busy        = (w_count != '0) || (r_state != RUN);

    gain_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_issue),
        .din     (w_grant == RIGHT),
        .pop     (w_retire),
        .dout    (w_tag_head),
        .full    (w_tag_full),
        .empty   (w_tag_empty),
        .count   (w_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= RUN;
            r_last_grant  <= RIGHT;
            r_volume      <= VOLUME_RESET;
            r_pending_vol <= '0;
        end else begin
            if (w_issue) r_last_grant <= w_grant;
            if (vol_req) r_pending_vol <= vol_in;
            case (r_state)
                RUN: begin
                    if (vol_req) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_count == '0) r_state <= LOAD;
                end
                LOAD: begin
                    // A request landing in this cycle is the newest value.
                    r_volume <= vol_req ? vol_in : r_pending_vol;
                    r_state  <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gain_scheduler.sv
// ============================================================================
// tb_gain_scheduler : cycle model plus directed scenarios for gain_scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_gain_scheduler;

    localparam int MAXO = 4;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [31:0] left_in, right_in, mul_din, mul_dout, volume, vol_in;
    logic signed [31:0] left_out, right_out;
    logic               left_empty, right_empty, left_rd_en, right_rd_en;
    logic               mul_wr_en, mul_full, mul_empty, mul_rd_en, vol_req;
    logic               left_wr_en, right_wr_en, left_full, right_full, busy;
`ifdef GAIN_SCHED_MUTE_EN
    logic               mute = 1'b0;
`endif

    always #5 clock = ~clock;

    gain_scheduler dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .left_in     (left_in),
        .right_in    (right_in),
        .left_empty  (left_empty),
        .right_empty (right_empty),
        .left_rd_en  (left_rd_en),
        .right_rd_en (right_rd_en),
        .mul_din     (mul_din),
        .mul_wr_en   (mul_wr_en),
        .mul_full    (mul_full),
        .mul_dout    (mul_dout),
        .mul_empty   (mul_empty),
        .mul_rd_en   (mul_rd_en),
        .volume      (volume),
        .vol_in      (vol_in),
        .vol_req     (vol_req),
        .left_out    (left_out),
        .right_out   (right_out),
        .left_wr_en  (left_wr_en),
        .right_wr_en (right_wr_en),
        .left_full   (left_full),
        .right_full  (right_full),
`ifdef GAIN_SCHED_MUTE_EN
        .mute        (mute),
`endif
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    // Environment: input FIFOs, gain unit (result = 3 * sample), output logs.
    int lq[$], rq[$], mq[$], issue_log[$], lout[$], rout[$];
    bit hold = 1'b1;
    bit mfull = 1'b0;

    // Handshakes seen at the negedge, applied to the environment at the posedge.
    bit c_lrd, c_rrd, c_mwr, c_mrd, c_lwr, c_rwr;
    int c_din, c_lout, c_rout;

    // Reference model state.
    bit m_tags[$];
    bit m_last  = 1'b1;
    int m_phase = 0;
    int m_pend  = 0;
    int m_vol   = 1024;

    bit el, er, iss, g, ret, hd;
    int sz, e_din, smp;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        left_in     = (lq.size() > 0) ? lq[0] : 0;
        left_empty  = (lq.size() == 0);
        right_in    = (rq.size() > 0) ? rq[0] : 0;
        right_empty = (rq.size() == 0);
        mul_empty   = hold || (mq.size() == 0);
        mul_dout    = mul_empty ? 0 : mq[0];
        mul_full    = mfull;
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(lq.size() == 0 && rq.size() == 0 && mq.size() == 0 && !busy) && n < budget) begin
            tick();
            n++;
        end
        if (!(lq.size() == 0 && rq.size() == 0 && mq.size() == 0 && !busy)) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: timeout after %0d cycles", budget);
        end
    endtask

    always @(posedge clock) begin
        if (reset_n) begin
            if (c_lrd) void'(lq.pop_front());
            if (c_rrd) void'(rq.pop_front());
            if (c_mrd) void'(mq.pop_front());
            if (c_mwr) begin
                mq.push_back(c_din * 3);
                issue_log.push_back(c_din);
            end
            if (c_lwr) lout.push_back(c_lout);
            if (c_rwr) rout.push_back(c_rout);
        end
        #1 refresh();
    end

    // Every cycle: derive expected outputs from the scheduling rules, compare, advance.
    always @(negedge clock) begin
        {c_lrd, c_rrd, c_mwr, c_mrd, c_lwr, c_rwr} = '0;
        if (!reset_n) begin
            m_tags.delete();
            m_last = 1'b1; m_phase = 0; m_pend = 0; m_vol = 1024;
            chk("rst_rd_en",  {left_rd_en, right_rd_en}, 0);
            chk("rst_wr_en",  {left_wr_en, right_wr_en, mul_wr_en, mul_rd_en}, 0);
            chk("rst_busy",   busy, 0);
            chk("rst_volume", volume, 1024);
        end else begin
            el  = !left_empty;
            er  = !right_empty;
            sz  = m_tags.size();
            iss = (m_phase == 0) && !mul_full && (sz < MAXO) && (el || er);
            g   = (el && er) ? !m_last : !el;
            hd  = (sz > 0) ? m_tags[0] : 1'b0;
            ret = !mul_empty && (sz > 0) && !(hd ? right_full : left_full);
            e_din = iss ? (g ? right_in : left_in) : 0;
`ifdef GAIN_SCHED_MUTE_EN
            smp = mute ? 0 : mul_dout;
`else
            smp = mul_dout;
`endif
            chk("left_rd_en",  left_rd_en,  iss && !g);
            chk("right_rd_en", right_rd_en, iss && g);
            chk("mul_wr_en",   mul_wr_en,   iss);
            chk("mul_din",     mul_din,     e_din);
            chk("mul_rd_en",   mul_rd_en,   ret);
            chk("left_wr_en",  left_wr_en,  ret && !hd);
            chk("right_wr_en", right_wr_en, ret && hd);
            chk("left_out",    left_out,    (ret && !hd) ? smp : 0);
            chk("right_out",   right_out,   (ret && hd) ? smp : 0);
            chk("busy",        busy,        (sz > 0) || (m_phase != 0));
            chk("volume",      volume,      m_vol);

            c_lrd = left_rd_en;  c_rrd = right_rd_en;
            c_mwr = mul_wr_en;   c_mrd = mul_rd_en;
            c_lwr = left_wr_en;  c_rwr = right_wr_en;
            c_din = mul_din;     c_lout = left_out;  c_rout = right_out;

            if (ret) void'(m_tags.pop_front());
            if (iss) begin
                m_tags.push_back(g);
                m_last = g;
            end
            case (m_phase)
                0: if (vol_req) begin m_pend = vol_in; m_phase = 1; end
                1: begin
                    if (vol_req) m_pend = vol_in;
                    if (sz == 0) m_phase = 2;
                end
                default: begin
                    m_vol = vol_req ? vol_in : m_pend;
                    if (vol_req) m_pend = vol_in;
                    m_phase = 0;
                end
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[6];
        int vol_seen;
        exp_order = '{1, 10, 2, 20, 3, 30};
        vol_in = 0; vol_req = 0; left_full = 0; right_full = 0;
        refresh();
        repeat (2) @(posedge clock);
        #2;
        chk("reset_volume", volume, 1024);
        chk("reset_busy", busy, 0);
        reset_n = 1'b1;

        // Tie-break order with both channels loaded.
        hold = 0;
        lq = '{1, 2, 3};
        rq = '{10, 20, 30};
        refresh();
        wait_idle(60);
        chk("order_count", issue_log.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("order_item", (issue_log.size() > i) ? issue_log[i] : -1, exp_order[i]);
        chk("order_lout", (lout.size() == 3) ? lout[2] : -1, 9);
        chk("order_rout", (rout.size() == 3) ? rout[0] : -1, 30);
        issue_log.delete(); lout.delete(); rout.delete();

        // Outstanding limit with the gain unit holding its results.
        hold = 1;
        lq = '{5, 6, 7, 8, 9};
        refresh();
        repeat (8) tick();
        chk("limit_issues", issue_log.size(), 4);
        chk("limit_busy", busy, 1);
        chk("limit_rd_en", left_rd_en, 0);
        chk("limit_left_left", lq.size(), 1);
        hold = 0;
        refresh();
        wait_idle(60);
        chk("limit_lout_n", lout.size(), 5);
        chk("limit_lout_last", (lout.size() == 5) ? lout[4] : -1, 27);
        issue_log.delete(); lout.delete(); rout.delete();

        // Blocked right destination stalls everything behind it.
        right_full = 1;
        rq = '{1, 2, 3};
        lq = '{4};
        refresh();
        repeat (8) tick();
        chk("stall_lout", lout.size(), 0);
        chk("stall_rout", rout.size(), 0);
        chk("stall_issues", issue_log.size(), 4);
        chk("stall_first", (issue_log.size() > 0) ? issue_log[0] : -1, 1);
        right_full = 0;
        refresh();
        wait_idle(60);
        chk("stall_rout_n", rout.size(), 3);
        chk("stall_rout_last", (rout.size() == 3) ? rout[2] : -1, 9);
        chk("stall_lout_v", (lout.size() == 1) ? lout[0] : -1, 12);
        issue_log.delete(); lout.delete(); rout.delete();

        // Volume change waits for the pipeline to drain.
        hold = 1;
        lq = '{1, 2, 3};
        refresh();
        repeat (5) tick();
        chk("vol_outstanding", issue_log.size(), 3);
        vol_in = 2048; vol_req = 1;
        tick();
        vol_req = 0; vol_in = 0;
        lq.push_back(7);
        hold = 0;
        refresh();
        chk("vol_busy", busy, 1);
        vol_seen = 0;
        for (int i = 0; i < 30 && vol_seen == 0; i++) begin
            tick();
            if (volume == 2048) begin
                vol_seen = 1;
                chk("vol_no_issue_in_drain", issue_log.size(), 3);
            end
        end
        chk("vol_seen", vol_seen, 1);
        wait_idle(60);
        chk("vol_resume", (issue_log.size() == 4) ? issue_log[3] : -1, 7);
        chk("vol_final", volume, 2048);
        issue_log.delete(); lout.delete(); rout.delete();

        // Asynchronous reset in the middle of traffic.
        hold = 1;
        lq = '{1, 2};
        refresh();
        repeat (4) tick();
        lq.push_back(5);
        refresh();
        reset_n = 0;
        mq.delete();
        refresh();
        #1;
        chk("mid_rst_rd_en", left_rd_en, 0);
        chk("mid_rst_mul", {mul_wr_en, mul_rd_en}, 0);
        chk("mid_rst_volume", volume, 1024);
        chk("mid_rst_busy", busy, 0);
        repeat (2) tick();
        reset_n = 1;
        hold = 0;
        refresh();
        wait_idle(60);
        chk("post_rst_lout", (lout.size() == 1) ? lout[0] : -1, 15);
        issue_log.delete(); lout.delete(); rout.delete();

`ifdef GAIN_SCHED_MUTE_EN
        mute = 1;
        lq = '{500};
        refresh();
        wait_idle(60);
        chk("mute_writes", lout.size(), 1);
        chk("mute_value", (lout.size() == 1) ? lout[0] : -1, 0);
        mute = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
